// File: rtl/seq_divider_gen_if.sv
// Register bus for seq_divider_gen.
//   address    : register byte offset
//   write_data : write data, sampled with we on the rising clock edge
//   read_data  : combinational read data for address
//   we / re    : write / read strobes (reads have no side effects)
//   irq        : level interrupt, STATUS.done & CTRL.irq_en
interface seq_divider_gen_if;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        we;
  logic        re;
  logic        irq;

  modport master (output address, write_data, we, re, input read_data, irq);
  modport slave  (input address, write_data, we, re, output read_data, irq);
endinterface

// File: rtl/seq_divider_gen.sv
// Sequential restoring divider with a small register file.
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset
//   bus : register bus (slave side)
// Map: 0x00 STATUS {ovf,dz,done,busy}, 0x04 DIVIDEND, 0x08 DIVISOR (write
// starts an op), 0x0C QUOTIENT, 0x10 REMAINDER, 0x14 CTRL {irq_en,signed}.
// An op takes WIDTH CALC cycles plus one FIX cycle for sign correction.
module seq_divider_gen #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  seq_divider_gen_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [WIDTH-1:0] dvd_r, dvs_r;
  logic [31:0]      quo_r, rem_r;
  logic             ctrl_sgn, ctrl_ie;
  logic             done, dz, ovf;

  // datapath for the op in flight
  logic [WIDTH:0]   acc;     // partial remainder, one guard bit
  logic [WIDTH-1:0] qsh;     // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] dmag;    // divisor magnitude
  logic [CW-1:0]    cnt;
  logic             q_neg, r_neg, op_sgn, ovf_pend;

  // zero-extend a WIDTH value to the bus width
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // sign-extend when s, else zero-extend
  function automatic logic [31:0] ext(input logic [WIDTH-1:0] v, input logic s);
    logic [31:0] r;
    r = {32{s & v[WIDTH-1]}};
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  logic             busy;
  logic             wr_status, wr_dvd, wr_dvs, wr_ctrl;
  logic [WIDTH-1:0] wd;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   acc_sh, diff;
  logic             take;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign busy      = (state != S_IDLE);
  assign wr_status = bus.we && (bus.address == 8'h00);
  assign wr_dvd    = bus.we && (bus.address == 8'h04);
  assign wr_dvs    = bus.we && (bus.address == 8'h08);
  assign wr_ctrl   = bus.we && (bus.address == 8'h14);
  assign wd        = bus.write_data[WIDTH-1:0];

  // ctrl_sgn can only ever hold 1 when SIGNED_EN, so it is the mode bit
  assign dvd_neg = ctrl_sgn & dvd_r[WIDTH-1];
  assign dvs_neg = ctrl_sgn & wd[WIDTH-1];
  assign dvd_abs = dvd_neg ? -dvd_r : dvd_r;
  assign dvs_abs = dvs_neg ? -wd : wd;

  // restoring step: shift in next dividend bit, subtract if it fits
  assign acc_sh = {acc[WIDTH-1:0], qsh[WIDTH-1]};
  assign diff   = acc_sh - {1'b0, dmag};
  assign take   = ~diff[WIDTH];

  assign q_fix = q_neg ? -qsh : qsh;
  assign r_fix = r_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      dvd_r    <= '0;
      dvs_r    <= '0;
      quo_r    <= '0;
      rem_r    <= '0;
      ctrl_sgn <= 1'b0;
      ctrl_ie  <= 1'b0;
      done     <= 1'b0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
      acc      <= '0;
      qsh      <= '0;
      dmag     <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      op_sgn   <= 1'b0;
      ovf_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_dvd)  dvd_r <= wd;
          if (wr_ctrl) begin
            ctrl_sgn <= SIGNED_EN & bus.write_data[0];
            ctrl_ie  <= bus.write_data[1];
          end
          if (wr_status && bus.write_data[1]) done <= 1'b0;
          if (wr_dvs) begin
            dvs_r <= wd;
            if (wd == '0) begin
              // divide by zero resolves immediately, no CALC
              quo_r <= ext('1, ctrl_sgn);
              rem_r <= ext(dvd_r, ctrl_sgn);
              dz    <= 1'b1;
              done  <= 1'b1;
              ovf   <= 1'b0;
            end else begin
              acc      <= '0;
              qsh      <= dvd_abs;
              dmag     <= dvs_abs;
              q_neg    <= dvd_neg ^ dvs_neg;
              r_neg    <= dvd_neg;
              op_sgn   <= ctrl_sgn;
              // MIN / -1: magnitude path already yields MIN, just flag it
              ovf_pend <= ctrl_sgn && (dvd_r == MIN_NEG) && (wd == '1);
              done     <= 1'b0;
              dz       <= 1'b0;
              ovf      <= 1'b0;
              cnt      <= CW'(WIDTH-1);
              state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= take ? diff : acc_sh;
          qsh <= {qsh[WIDTH-2:0], take};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_FIX;
        end
        S_FIX: begin
          quo_r <= ext(q_fix, op_sgn);
          rem_r <= ext(r_fix, op_sgn);
          ovf   <= ovf_pend;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.read_data = '0;
    case (bus.address)
      8'h00: bus.read_data = {28'd0, ovf, dz, done, busy};
      8'h04: bus.read_data = zext(dvd_r);
      8'h08: bus.read_data = zext(dvs_r);
      8'h0C: bus.read_data = quo_r;
      8'h10: bus.read_data = rem_r;
      8'h14: bus.read_data = {30'd0, ctrl_ie, ctrl_sgn};
      default: bus.read_data = '0;
    endcase
  end

  assign bus.irq = done & ctrl_ie;

  // reads have no side effects; upper write bits beyond WIDTH are don't-care
  logic unused_bus;
  assign unused_bus = &{1'b0, bus.re, bus.write_data};
endmodule

// File: tb/tb_seq_divider_gen.sv
// Directed bench for seq_divider_gen: a WIDTH=32 and a WIDTH=8 instance
// share clk/rst. Inputs are driven 1 time unit after posedge, reads sampled
// at negedge, busy polled just after each posedge.
module tb_seq_divider_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_divider_gen_if b32();
  seq_divider_gen_if b8();

  seq_divider_gen #(.WIDTH(32), .SIGNED_EN(1)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  seq_divider_gen #(.WIDTH(8),  .SIGNED_EN(1)) dut8  (.clk(clk), .rst(rst), .bus(b8));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // s selects the instance: 0 = WIDTH 32, 1 = WIDTH 8
  task automatic wr(input int s, input logic [7:0] a, input logic [31:0] d);
    if (s == 0) begin b32.address = a; b32.write_data = d; b32.we = 1'b1; end
    else        begin b8.address  = a; b8.write_data  = d; b8.we  = 1'b1; end
    @(posedge clk); #1;
    b32.we = 1'b0;
    b8.we  = 1'b0;
  endtask

  task automatic rd(input int s, input logic [7:0] a, output logic [31:0] d);
    if (s == 0) begin b32.address = a; b32.re = 1'b1; end
    else        begin b8.address  = a; b8.re  = 1'b1; end
    @(negedge clk);
    d = (s == 0) ? b32.read_data : b8.read_data;
    b32.re = 1'b0;
    b8.re  = 1'b0;
  endtask

  // counts cycles with STATUS.busy=1; also reports whether irq was seen while busy
  task automatic wait_idle(input int s, output int n, output logic irq_busy);
    logic bsy;
    n = 0;
    irq_busy = 1'b0;
    if (s == 0) b32.address = 8'h00; else b8.address = 8'h00;
    #1;
    bsy = (s == 0) ? b32.read_data[0] : b8.read_data[0];
    while (bsy && n < 200) begin
      n++;
      irq_busy |= (s == 0) ? b32.irq : b8.irq;
      step();
      bsy = (s == 0) ? b32.read_data[0] : b8.read_data[0];
    end
  endtask

  logic [31:0] d;
  int          n;
  logic        ib;

  initial begin
    b32.address = '0; b32.write_data = '0; b32.we = 1'b0; b32.re = 1'b0;
    b8.address  = '0; b8.write_data  = '0; b8.we  = 1'b0; b8.re  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    rd(0, 8'h00, d); chk("rst_status", d, 32'h0);
    rd(0, 8'h0C, d); chk("rst_quot", d, 32'h0);
    rd(0, 8'h14, d); chk("rst_ctrl", d, 32'h0);
    chk("rst_irq", {31'd0, b32.irq}, 32'h0);
    step();

    // unsigned 100/7
    wr(0, 8'h04, 32'd100);
    wr(0, 8'h08, 32'd7);
    wait_idle(0, n, ib);
    chk("u100_7_busy", n, 32'd33);
    rd(0, 8'h0C, d); chk("u100_7_quot", d, 32'd14);
    rd(0, 8'h10, d); chk("u100_7_rem", d, 32'd2);
    rd(0, 8'h00, d); chk("u100_7_status", d, 32'h2);
    step();

    // signed -7/2 and 7/-2
    wr(0, 8'h14, 32'h1);
    wr(0, 8'h04, 32'hFFFF_FFF9);
    wr(0, 8'h08, 32'd2);
    wait_idle(0, n, ib);
    rd(0, 8'h0C, d); chk("sm7_2_quot", d, 32'hFFFF_FFFD);
    rd(0, 8'h10, d); chk("sm7_2_rem", d, 32'hFFFF_FFFF);
    step();
    wr(0, 8'h04, 32'd7);
    wr(0, 8'h08, 32'hFFFF_FFFE);
    wait_idle(0, n, ib);
    rd(0, 8'h0C, d); chk("s7_m2_quot", d, 32'hFFFF_FFFD);
    rd(0, 8'h10, d); chk("s7_m2_rem", d, 32'h1);
    step();

    // divide by zero: 5/0
    wr(0, 8'h14, 32'h0);
    wr(0, 8'h04, 32'd5);
    wr(0, 8'h08, 32'd0);
    wait_idle(0, n, ib);
    chk("dz_busy", n, 32'd0);
    rd(0, 8'h0C, d); chk("dz_quot", d, 32'hFFFF_FFFF);
    rd(0, 8'h10, d); chk("dz_rem", d, 32'd5);
    rd(0, 8'h00, d); chk("dz_status", d, 32'h6);
    step();

    // signed overflow: MIN / -1
    wr(0, 8'h14, 32'h1);
    wr(0, 8'h04, 32'h8000_0000);
    wr(0, 8'h08, 32'hFFFF_FFFF);
    wait_idle(0, n, ib);
    chk("ovf_busy", n, 32'd33);
    rd(0, 8'h0C, d); chk("ovf_quot", d, 32'h8000_0000);
    rd(0, 8'h10, d); chk("ovf_rem", d, 32'h0);
    rd(0, 8'h00, d); chk("ovf_status", d, 32'hA);
    step();

    // irq with 9/3, writes while busy are ignored
    wr(0, 8'h00, 32'h2);
    wr(0, 8'h14, 32'h2);
    chk("irq_idle", {31'd0, b32.irq}, 32'h0);
    wr(0, 8'h04, 32'd9);
    wr(0, 8'h08, 32'd3);
    repeat (3) step();
    wr(0, 8'h14, 32'h0);
    wr(0, 8'h08, 32'd1);
    wait_idle(0, n, ib);
    chk("irq_low_busy", {31'd0, ib}, 32'h0);
    chk("irq_done", {31'd0, b32.irq}, 32'h1);
    rd(0, 8'h0C, d); chk("irq_quot", d, 32'd3);
    rd(0, 8'h10, d); chk("irq_rem", d, 32'd0);
    rd(0, 8'h08, d); chk("busy_dvs_ign", d, 32'd3);
    rd(0, 8'h14, d); chk("busy_ctrl_ign", d, 32'h2);
    wr(0, 8'h00, 32'h2);
    chk("irq_clear", {31'd0, b32.irq}, 32'h0);
    rd(0, 8'h00, d); chk("clr_status", d, 32'h0);
    step();

    // reset mid-CALC, then a fresh op
    wr(0, 8'h04, 32'd100);
    wr(0, 8'h08, 32'd7);
    repeat (10) step();
    rst = 1'b1;
    #1;
    rd(0, 8'h00, d); chk("mid_rst_status", d, 32'h0);
    rd(0, 8'h0C, d); chk("mid_rst_quot", d, 32'h0);
    chk("mid_rst_irq", {31'd0, b32.irq}, 32'h0);
    step();
    rst = 1'b0;
    step();
    wr(0, 8'h04, 32'd100);
    wr(0, 8'h08, 32'd7);
    wait_idle(0, n, ib);
    chk("post_rst_busy", n, 32'd33);
    rd(0, 8'h0C, d); chk("post_rst_quot", d, 32'd14);
    rd(0, 8'h10, d); chk("post_rst_rem", d, 32'd2);
    step();

    // WIDTH=8: 200/3, upper dividend bits dropped
    wr(1, 8'h04, 32'hFFFF_FFC8);
    rd(1, 8'h04, d); chk("w8_dvd_trunc", d, 32'hC8);
    step();
    wr(1, 8'h08, 32'd3);
    wait_idle(1, n, ib);
    chk("w8_busy", n, 32'd9);
    rd(1, 8'h0C, d); chk("w8_quot", d, 32'd66);
    rd(1, 8'h10, d); chk("w8_rem", d, 32'd2);
    rd(1, 8'h00, d); chk("w8_status", d, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/seq_divider_gen.md
SEQ_DIVIDER_GEN -- requirements
Module: seq_divider_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width (legal range 4..32).
REQ-002 SHALL have parameter SIGNED_EN, default 1; 1 means signed mode is selectable, 0 means CTRL.signed is forced to 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port address, input, 8 bits: register byte offset.
REQ-006 SHALL have port write_data, input, 32 bits: bus write data.
REQ-007 SHALL have port read_data, output, 32 bits: combinational read data for address.
REQ-008 SHALL have port we, input, 1 bit: write strobe, sampled on the clock edge.
REQ-009 SHALL have port re, input, 1 bit: read strobe; no read side effects.
REQ-010 SHALL have port irq, output, 1 bit: level interrupt, equal to STATUS.done AND CTRL.irq_en.

Function
REQ-011 SHALL decode the register map as follows; unmapped offsets read 0 and ignore writes:
- 0x00 STATUS: bit0 busy, bit1 done, bit2 dz, bit3 ovf.
- 0x04 DIVIDEND: R/W.
- 0x08 DIVISOR: R/W; a write starts an operation.
- 0x0C QUOTIENT: RO.
- 0x10 REMAINDER: RO.
- 0x14 CTRL: bit0 signed, bit1 irq_en, R/W.
REQ-012 SHALL use only bits [WIDTH-1:0] of DIVIDEND and DIVISOR; reads of these return the stored value with upper bits 0.
REQ-013 SHALL have FSM states IDLE, CALC and FIX; busy SHALL be 1 in CALC and FIX only.
REQ-014 In IDLE, a DIVISOR write with a nonzero value SHALL:
- latch the divisor;
- load the operand magnitudes (absolute values when signed=1);
- record the quotient and remainder signs;
- clear done, dz and ovf;
- enter CALC with an iteration counter of WIDTH-1.
REQ-015 CALC SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit MSB-first, and SHALL go to FIX after the counter reaches 0, i.e. after exactly WIDTH cycles.
REQ-016 FIX SHALL apply sign correction:
- quotient negated when the operand signs differ;
- remainder takes the dividend's sign.
It SHALL then write QUOTIENT and REMAINDER, set done, and return to IDLE in one cycle.
REQ-017 Latency: for a DIVISOR write at edge E0, busy SHALL read 1 for exactly WIDTH+1 cycles, and results and done SHALL be visible after edge E0+WIDTH+1.
REQ-018 Result registers SHALL be sign-extended from WIDTH to 32 bits when signed=1, and zero-extended otherwise.
REQ-019 A DIVISOR write of 0 in IDLE SHALL, at the next edge and without entering CALC:
- set QUOTIENT to all ones over WIDTH bits (extended per REQ-018);
- set REMAINDER to the dividend;
- set dz=1 and done=1.
REQ-020 Signed dividend -2^(WIDTH-1) divided by -1 SHALL produce QUOTIENT=-2^(WIDTH-1), REMAINDER=0 and ovf=1, with normal latency.
REQ-021 While busy, writes to DIVIDEND, DIVISOR and CTRL SHALL be ignored (no restart), and QUOTIENT/REMAINDER SHALL hold their previous results.
REQ-022 Writing 1 to STATUS bit1 SHALL clear done; other STATUS bits SHALL be read-only.
REQ-023 If a done-clear write coincides with completion (FIX), done SHALL end up 1.
REQ-024 STATUS writes while busy SHALL be ignored.
REQ-025 When SIGNED_EN=0, CTRL bit0 SHALL read 0 and all operations SHALL be unsigned.

Reset
REQ-026 On rst=1, regardless of clock or current state, the block SHALL asynchronously:
- clear all registers, the counter and flags to 0;
- set the FSM to IDLE;
- drive irq=0 and busy=0.
An operation in progress SHALL be abandoned with no result written.
REQ-027 After rst deasserts, the first DIVISOR write SHALL start a fresh operation with the full latency of REQ-017.

Verification
REQ-028 Bench SHALL cover: unsigned, WIDTH=32, 100/7 -> busy for 33 cycles, then QUOTIENT=14, REMAINDER=2, done=1, dz=0.
REQ-029 Bench SHALL cover: signed, -7/2 -> QUOTIENT=0xFFFFFFFD, REMAINDER=0xFFFFFFFF; and 7/-2 -> QUOTIENT=0xFFFFFFFD, REMAINDER=1.
REQ-030 Bench SHALL cover: 5/0 -> after 1 cycle QUOTIENT=0xFFFFFFFF, REMAINDER=5, dz=1, done=1, busy never 1.
REQ-031 Bench SHALL cover: signed 0x80000000 / 0xFFFFFFFF -> QUOTIENT=0x80000000, REMAINDER=0, ovf=1.
REQ-032 Bench SHALL cover: irq_en=1, run 9/3 -> irq rises with done, then a STATUS write of 0x2 drops irq next cycle; a DIVISOR write of 1 mid-operation is ignored, so the result stays QUOTIENT=3.
REQ-033 Bench SHALL cover: rst pulse at CALC cycle 10 -> busy=0, QUOTIENT=0, done=0 immediately; with WIDTH=8, 200/3 -> busy for 9 cycles, QUOTIENT=66, REMAINDER=2.
